// File: rtl/jpeg_idct_transpose_buf_pkg.sv
// Shared definitions for the IDCT transpose buffer: default block geometry,
// coefficient width and the read-side FSM state type.
package jpeg_idct_transpose_buf_pkg;

  localparam int unsigned JPEG_BLK_N  = 8;
  localparam int unsigned JPEG_COEF_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/jpeg_idct_transpose_buf_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address = {bank, idx}.
// Synchronous write, registered read that holds its value when no read is
// enabled, so an issued-but-unconsumed element stays available.
module jpeg_transpose_bank_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, updated only on an issued read
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jpeg_idct_transpose_buf.sv
// Ping-pong NxN transpose store between the IDCT row and column passes.
// Row-major elements in, column-major elements out, valid/ready on both sides.
// Optional macro JPEG_TRANSPOSE_STATS_EN adds blk_count_o, a wrapping count of
// completed output blocks.
module jpeg_idct_transpose_buf
  import jpeg_idct_transpose_buf_pkg::*;
#(
  parameter int unsigned DATA_W = JPEG_COEF_W,
  parameter int unsigned N      = JPEG_BLK_N
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              err_o
`ifdef JPEG_TRANSPOSE_STATS_EN
  ,
  output logic [15:0]       blk_count_o
`endif
);

  localparam int unsigned   AW       = $clog2(N*N);
  localparam int unsigned   LB       = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N*N-1);

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     rd_addr;
  logic              wr_en;
  logic              wr_done;
  logic              rd_en;
  logic              rd_done;
  logic              slot_free;
  logic              rd_pend;
  logic              rd_pend_last;
  logic [DATA_W-1:0] ram_q;
  rd_state_e         state;
  rd_state_e         state_next;

  assign in_ready_o = !full[wr_bank];
  assign wr_en      = in_valid_i && in_ready_o;
  assign wr_done    = wr_en && (wr_idx == LAST_IDX);
  assign slot_free  = !out_valid_o || out_ready_i;
  assign rd_done    = rd_en && (rd_idx == LAST_IDX);
  // Swap row and column fields of the element index
  assign rd_addr    = {rd_idx[LB-1:0], rd_idx[AW-1:LB]};

  jpeg_transpose_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (in_data_i),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (ram_q)
  );

  // Write index and write bank advance on each accepted element
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      if (wr_done) begin
        wr_idx  <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_idx <= wr_idx + AW'(1);
      end
    end
  end

  // Sticky flag when in_last disagrees with the write position
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (wr_en && (in_last_i != (wr_idx == LAST_IDX))) begin
      err_o <= 1'b1;
    end
  end

  // Bank full flags: set by the final write, cleared by the final read issue
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full <= '0;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Read FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (full[rd_bank]) state_next = STREAM;
      STREAM: if (rd_done)       state_next = full[!rd_bank] ? STREAM : IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Read FSM output: the first element may issue in the same cycle the block is seen
  always_comb begin
    rd_en = 1'b0;
    case (state)
      IDLE:    rd_en = full[rd_bank] && slot_free;
      STREAM:  rd_en = slot_free;
      default: rd_en = 1'b0;
    endcase
  end

  // Read index and read bank advance on each issued read
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_en) begin
      if (rd_done) begin
        rd_idx  <= '0;
        rd_bank <= !rd_bank;
      end else begin
        rd_idx <= rd_idx + AW'(1);
      end
    end
  end

  // Tracks the element sitting in the RAM read register awaiting the output stage.
  // A read issues only when the output stage is free, so this never gets overwritten.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else if (rd_en) begin
      rd_pend      <= 1'b1;
      rd_pend_last <= (rd_idx == LAST_IDX);
    end else if (slot_free) begin
      rd_pend      <= 1'b0;
    end
  end

  // Output register: loads the pending element whenever it is empty or being consumed
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_data_o  <= '0;
    end else if (slot_free) begin
      out_valid_o <= rd_pend;
      out_last_o  <= rd_pend && rd_pend_last;
      if (rd_pend) out_data_o <= ram_q;
    end
  end

`ifdef JPEG_TRANSPOSE_STATS_EN
  // Completed output block counter, wraps naturally at 16 bits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      blk_count_o <= '0;
    end else if (out_valid_o && out_ready_i && out_last_o) begin
      blk_count_o <= blk_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_idct_transpose_buf.sv
// Self-checking bench for jpeg_idct_transpose_buf (N=8, DATA_W=16).
// Reference: each completed input block is transposed into an expected
// output queue; a negedge monitor compares every valid output against it.
module tb_jpeg_idct_transpose_buf;

  localparam int N  = 8;
  localparam int NN = N * N;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          err;
`ifdef JPEG_TRANSPOSE_STATS_EN
  logic [15:0]   blk_count;
`endif

  jpeg_idct_transpose_buf #(
    .DATA_W (DW),
    .N      (N)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .err_o       (err)
`ifdef JPEG_TRANSPOSE_STATS_EN
    ,
    .blk_count_o (blk_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] cur_blk [NN];
  logic [DW-1:0] blk_a [NN];
  int            cur_cnt = 0;
  int            blocks_done = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            rdy_mode = 0;
  bit            gap_en = 1'b0;
  bit            seen_first = 1'b0;
  int            gap_cnt = 0;
  int            stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: collect a row-major block, then queue it in column-major order
  task automatic model_push(input logic [DW-1:0] d);
    cur_blk[cur_cnt] = d;
    cur_cnt++;
    if (cur_cnt == NN) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < N; r++)
          exp_q.push_back('{d: cur_blk[r*N + c], l: (c == N-1) && (r == N-1)});
      cur_cnt = 0;
      blocks_done++;
    end
  endtask

  // Present one element from posedge+1; return at posedge+1 after its handshake
  task automatic push_elem(input logic [DW-1:0] d, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      stall_cnt++;
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
      model_push(d);
    end else begin
      chk("push_timeout", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_rand_block();
    for (int i = 0; i < NN; i++) push_elem(16'($urandom()), i == NN-1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once
  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    cur_cnt = 0;
    blocks_done = 0;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_last"}, 32'(out_last), 0);
    chk({tag, "_err"}, 32'(err), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Downstream ready pattern: 0 always-ready, 1 stalled, 2 random 50%
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (gap_en && seen_first && exp_q.size() > 0 && !out_valid) gap_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_last", 32'(out_last), 32'(exp_q[0].l));
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen_first = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Single block 0..63, latency from last write to first output
    rdy_mode = 0;
    for (int i = 0; i < NN; i++) push_elem(16'(i), i == NN-1);
    @(negedge clk); chk("lat_e0", 32'(out_valid), 0);
    @(negedge clk); chk("lat_e1", 32'(out_valid), 0);
    @(negedge clk); chk("lat_e2", 32'(out_valid), 1);
    chk("lat_first_data", 32'(out_data), 0);
    drain("single_drain");

    // Three back-to-back blocks: no input stall, no output gap
    stall_cnt = 0; gap_cnt = 0; seen_first = 1'b0; gap_en = 1'b1;
    repeat (3) push_rand_block();
    drain("b2b_drain");
    gap_en = 1'b0;
    chk("b2b_in_stall", stall_cnt, 0);
    chk("b2b_out_gaps", gap_cnt, 0);

    // Backpressure: both banks fill, output held, then release
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NN; i++) begin
      blk_a[i] = 16'($urandom());
      push_elem(blk_a[i], i == NN-1);
    end
    push_rand_block();
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data_held", 32'(out_data), 32'(blk_a[0]));
    repeat (10) @(negedge clk);
    chk("bp_in_ready_still_low", 32'(in_ready), 0);
    chk("bp_data_still_held", 32'(out_data), 32'(blk_a[0]));
    @(posedge clk); #1;
    rdy_mode = 0;
    push_rand_block();
    drain("bp_drain");

    // Misplaced in_last at index 10: sticky error, data unaffected
    chk("err_before", 32'(err), 0);
    for (int i = 0; i < NN; i++) begin
      push_elem(16'($urandom()), (i == 10) || (i == NN-1));
      if (i == 10) chk("err_set", 32'(err), 1);
    end
    drain("err_drain");
    chk("err_sticky", 32'(err), 1);
    do_reset("err_reset");

    // Reset mid-write (index 30)
    for (int i = 0; i < 30; i++) push_elem(16'($urandom()), 1'b0);
    do_reset("midwr_reset");
    v = 0;
    repeat (5) begin @(negedge clk); v += int'(out_valid); end
    chk("midwr_no_output", v, 0);
    @(posedge clk); #1;

    // Reset mid-read (after ~20 outputs)
    push_rand_block();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_q.size() <= NN - 20) break;
    end
    chk("midrd_progress", 32'(exp_q.size() <= NN - 20), 1);
    @(posedge clk);
    do_reset("midrd_reset");
    v = 0;
    repeat (5) begin @(negedge clk); v += int'(out_valid); end
    chk("midrd_no_output", v, 0);
    chk("midrd_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    push_rand_block();
    drain("post_reset_drain");

    // Random downstream ready over 20 blocks
    do_reset("rand_reset");
    rdy_mode = 2;
    repeat (20) push_rand_block();
    drain("rand_drain");
    rdy_mode = 0;
`ifdef JPEG_TRANSPOSE_STATS_EN
    chk("blk_count", 32'(blk_count), 32'(blocks_done));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
